hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 13 +
 rtl/hazard_scoreboard_cnt.sv | 38 +++
 rtl/hazard_scoreboard.sv | 93 +++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared cpu constants for the ID-stage hazard scoreboard: register address width,
// default producer latency bound and the latency codes used by the decoder.
package hazard_scoreboard_pkg;

    localparam int ADDR_W      = 5;
    localparam int NUM_REGS    = 1 << ADDR_W;
    localparam int DEF_MAX_LAT = 4;
    localparam int LAT_W       = $clog2(DEF_MAX_LAT + 1);

    localparam logic [LAT_W-1:0] LAT_ALU  = LAT_W'(0);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(1);

endpackage

// File: rtl/hazard_scoreboard_cnt.sv
// One per-register countdown: cycles remaining until the register's pending result
// can be consumed. A new write keeps the later of the old and new completion times.
module hazard_cnt #(
    parameter int W = hazard_scoreboard_pkg::LAT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         wr_i,
    input  logic [W-1:0] lat_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_dec;
    logic [W-1:0] w_next;

    always_comb begin
        w_dec  = (r_cnt == '0) ? '0 : r_cnt - W'(1);
        w_next = w_dec;
        if (wr_i && (lat_i > w_dec)) begin
            w_next = lat_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every counter samples
    // the pre-edge values; blocking here would create simulation order races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_next;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard with per-register latency countdowns.
// Optional HAZARD_PERF_EN adds a 32-bit wrapping stall-cycle counter (stall_cnt_o).
module hazard_scoreboard #(
    parameter  int NUM_REGS = 32,
    parameter  int ADDR_W   = hazard_scoreboard_pkg::ADDR_W,
    parameter  int MAX_LAT  = hazard_scoreboard_pkg::DEF_MAX_LAT,
    localparam int LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                id_valid_i,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   id_rs1_i,
    input  logic [ADDR_W-1:0]   id_rs2_i,
    input  logic                id_rs1_use_i,
    input  logic                id_rs2_use_i,
    input  logic [ADDR_W-1:0]   id_rd_i,
    input  logic                id_regwrite_i,
    input  logic [LAT_W-1:0]    id_lat_i,
    output logic                stall_o,
    output logic                pcwrite_o,
    output logic                noop_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]         stall_cnt_o,
`endif
    output logic [NUM_REGS-1:0] pending_o
);

    logic [LAT_W-1:0] w_cnt [NUM_REGS];
    logic [LAT_W-1:0] w_lat;
    logic             w_hazard;
    logic             w_present;
    logic             w_issue_wr;

    assign w_cnt[0] = '0;

    // NOTE: every signal written in always_comb gets its default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_lat = id_lat_i;
        if (id_lat_i > LAT_W'(MAX_LAT)) begin
            w_lat = LAT_W'(MAX_LAT);
        end
        w_hazard  = (id_rs1_use_i && (w_cnt[id_rs1_i] != '0))
                 || (id_rs2_use_i && (w_cnt[id_rs2_i] != '0));
        w_present = start_i && id_valid_i && !flush_i;
    end

    assign stall_o    = w_present && w_hazard;
    assign noop_o     = stall_o;
    assign pcwrite_o  = start_i && !stall_o;
    assign w_issue_wr = w_present && !w_hazard && id_regwrite_i && (id_rd_i != '0);

    // Counters only advance while running; a squashed or stalled write never reaches wr_i.
    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_cnt
            hazard_cnt #(
                .W(LAT_W)
            ) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (start_i),
                .wr_i  (w_issue_wr && (id_rd_i == ADDR_W'(g))),
                .lat_i (w_lat),
                .cnt_o (w_cnt[g])
            );
        end
    endgenerate

    always_comb begin
        pending_o = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_o[r] = (w_cnt[r] != '0);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (stall_o) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
